// File: rtl/cyq_sipo_rx_if.sv
// Signal bundle between cyq_sipo_rx, the upstream 74HC165-style register and the word consumer.
// CYQ_SIPO_RX_INV_CHK_EN adds the inverted serial input Yn_i and the sticky ERR flag.
interface cyq_sipo_rx_if #(
   parameter int unsigned WIDTH = 8
);
   logic             START;
   logic             PL_o;
   logic             CE_o;
   logic             Y_i;
   logic [WIDTH-1:0] Q;
   logic             VALID;
   logic             READY;
   logic             BUSY;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
   logic             Yn_i;
   logic             ERR;
`endif

   modport slave (
      input  START, Y_i, READY,
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      input  Yn_i,
      output ERR,
`endif
      output PL_o, CE_o, Q, VALID, BUSY
   );

   modport master (
      output START, Y_i, READY,
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      output Yn_i,
      input  ERR,
`endif
      input  PL_o, CE_o, Q, VALID, BUSY
   );
endinterface

// File: rtl/cyq_sipo_rx.sv
// Sequencer/deserializer for a parallel-load shift register: LOAD pulse, WIDTH shift cycles, valid/ready word.
// Optional CYQ_SIPO_RX_INV_CHK_EN: checks Y_i against Yn_i on every sample and raises sticky ERR.
module cyq_sipo_rx #(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic          CP,
   input logic          MR,
   cyq_sipo_rx_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic [WIDTH-1:0] sh, sh_d, sh_in;
   logic [WIDTH-1:0] q, q_d;
   logic             valid, valid_d;
   logic             pl, pl_d;
   logic             ce, ce_d;
   logic             busy, busy_d;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
   logic             err, err_d;
`endif

   // Y_i is sampled at the same edge the upstream register shifts, so it is the pre-shift bit.
   always_comb begin
      sh_in = MSB_FIRST ? {sh[WIDTH-2:0], bus.Y_i} : {bus.Y_i, sh[WIDTH-1:1]};
   end

   always_ff @(posedge CP) begin
      if (MR) begin
         state <= IDLE;
         cnt   <= '0;
         sh    <= '0;
         q     <= '0;
         valid <= 1'b0;
         pl    <= 1'b1;
         ce    <= 1'b1;
         busy  <= 1'b0;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
         err   <= 1'b0;
`endif
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
         sh    <= sh_d;
         q     <= q_d;
         valid <= valid_d;
         pl    <= pl_d;
         ce    <= ce_d;
         busy  <= busy_d;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
         err   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      sh_d    = sh;
      q_d     = q;
      valid_d = valid;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      err_d   = err;
`endif
      case (state)
         IDLE: begin
            if (bus.START && !valid) begin
               state_d = LOAD;
               cnt_d   = '0;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
               err_d   = 1'b0;
`endif
            end
         end
         LOAD: begin
            state_d = SHIFT;
            cnt_d   = '0;
         end
         SHIFT: begin
            sh_d  = sh_in;
            cnt_d = cnt + CNT_W'(1);
`ifdef CYQ_SIPO_RX_INV_CHK_EN
            if (bus.Y_i == bus.Yn_i) err_d = 1'b1;
`endif
            if (cnt == CNT_W'(WIDTH - 1)) begin
               q_d     = sh_in;
               valid_d = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Accept and a new request on the same edge chain straight into the next frame.
            if (bus.READY) begin
               valid_d = 1'b0;
               if (bus.START) begin
                  state_d = LOAD;
                  cnt_d   = '0;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
                  err_d   = 1'b0;
`endif
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      pl_d   = (state_d != LOAD);
      ce_d   = (state_d != SHIFT);
      busy_d = (state_d == LOAD) || (state_d == SHIFT);
   end

   assign bus.PL_o  = pl;
   assign bus.CE_o  = ce;
   assign bus.Q     = q;
   assign bus.VALID = valid;
   assign bus.BUSY  = busy;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
   assign bus.ERR   = err;
`endif
endmodule

// File: tb/tb_cyq_sipo_rx.sv
// Directed bench for cyq_sipo_rx with a behavioural 74HC165 upstream model per instance.
module tb_cyq_sipo_rx;
   logic cp = 1'b0;
   logic mr;
   int   total = 0;
   int   bad   = 0;

   always #5 cp = ~cp;

   cyq_sipo_rx_if #(.WIDTH(8)) bm ();
   cyq_sipo_rx_if #(.WIDTH(8)) bl ();

   cyq_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (.CP(cp), .MR(mr), .bus(bm.slave));
   cyq_sipo_rx #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (.CP(cp), .MR(mr), .bus(bl.slave));

   // Upstream registers: async active-low load, shift toward D7 while CE is low, Y = bit 7.
   logic [7:0] dm = 8'h00;
   logic [7:0] dl = 8'h00;
   logic [7:0] rm = 8'h00;
   logic [7:0] rl = 8'h00;
   logic       force_en  = 1'b0;
   logic       force_val = 1'b0;
   logic       inj       = 1'b0;

   always @(posedge cp or negedge bm.PL_o) begin
      if (!bm.PL_o)      rm <= dm;
      else if (!bm.CE_o) rm <= {rm[6:0], 1'b0};
   end

   always @(posedge cp or negedge bl.PL_o) begin
      if (!bl.PL_o)      rl <= dl;
      else if (!bl.CE_o) rl <= {rl[6:0], 1'b0};
   end

   assign bm.Y_i = force_en ? force_val : rm[7];
   assign bl.Y_i = rl[7];
`ifdef CYQ_SIPO_RX_INV_CHK_EN
   assign bm.Yn_i = inj ? bm.Y_i : ~bm.Y_i;
   assign bl.Yn_i = ~bl.Y_i;
`endif

   task automatic tick(input int n);
      repeat (n) @(posedge cp);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      mr = 1'b1;
      bm.START = 1'b0; bm.READY = 1'b0;
      bl.START = 1'b0; bl.READY = 1'b0;
      tick(2);
      chk("rst_pl",    32'(bm.PL_o),  32'd1);
      chk("rst_ce",    32'(bm.CE_o),  32'd1);
      chk("rst_valid", 32'(bm.VALID), 32'd0);
      chk("rst_busy",  32'(bm.BUSY),  32'd0);
      chk("rst_q",     32'(bm.Q),     32'h00);
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      chk("rst_err",   32'(bm.ERR),   32'd0);
`endif

      // Single frame 0xB2, MSB first
      mr = 1'b0;
      dm = 8'hB2;
      bm.START = 1'b1;
      tick(1);
      bm.START = 1'b0;
      chk("load_pl",   32'(bm.PL_o), 32'd0);
      chk("load_ce",   32'(bm.CE_o), 32'd1);
      chk("load_busy", 32'(bm.BUSY), 32'd1);
      for (int i = 0; i < 8; i++) begin
         tick(1);
         chk("shift_ce",    32'(bm.CE_o),  32'd0);
         chk("shift_pl",    32'(bm.PL_o),  32'd1);
         chk("shift_valid", 32'(bm.VALID), 32'd0);
      end
      tick(1);
      chk("f1_valid", 32'(bm.VALID), 32'd1);
      chk("f1_q",     32'(bm.Q),     32'hB2);
      chk("f1_busy",  32'(bm.BUSY),  32'd0);
      chk("f1_ce",    32'(bm.CE_o),  32'd1);
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      chk("f1_err",   32'(bm.ERR),   32'd0);
`endif

      // Hold without READY; START pulses must be ignored
      for (int i = 0; i < 5; i++) begin
         bm.START = (i == 1 || i == 3);
         tick(1);
         chk("hold_q",     32'(bm.Q),     32'hB2);
         chk("hold_valid", 32'(bm.VALID), 32'd1);
         chk("hold_pl",    32'(bm.PL_o),  32'd1);
      end
      bm.START = 1'b0;
      bm.READY = 1'b1;
      tick(1);
      chk("hs_valid", 32'(bm.VALID), 32'd0);
      chk("hs_busy",  32'(bm.BUSY),  32'd0);
      tick(1);
      bm.READY = 1'b0;
      chk("idle_ready_valid", 32'(bm.VALID), 32'd0);
      chk("idle_ready_pl",    32'(bm.PL_o),  32'd1);
      chk("idle_q_kept",      32'(bm.Q),     32'hB2);

      // Frame 0x3C, with a Y==Yn fault on sample 3 when the checker is built in
      dm = 8'h3C;
      bm.START = 1'b1;
      tick(1);
      bm.START = 1'b0;
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      tick(3);
      inj = 1'b1;
      tick(1);
      inj = 1'b0;
      tick(5);
      chk("f2_err", 32'(bm.ERR), 32'd1);
`else
      tick(9);
`endif
      chk("f2_valid", 32'(bm.VALID), 32'd1);
      chk("f2_q",     32'(bm.Q),     32'h3C);

      // Back-to-back: READY and START on the same edge, next pattern 0x5A
      dm = 8'h5A;
      bm.READY = 1'b1;
      bm.START = 1'b1;
      tick(1);
      bm.READY = 1'b0;
      bm.START = 1'b0;
      chk("b2b_pl",    32'(bm.PL_o),  32'd0);
      chk("b2b_valid", 32'(bm.VALID), 32'd0);
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      chk("b2b_err_clr", 32'(bm.ERR), 32'd0);
`endif
      tick(8);
      chk("b2b_early_valid", 32'(bm.VALID), 32'd0);
      tick(1);
      chk("b2b_valid2", 32'(bm.VALID), 32'd1);
      chk("b2b_q",      32'(bm.Q),     32'h5A);
`ifdef CYQ_SIPO_RX_INV_CHK_EN
      chk("b2b_err", 32'(bm.ERR), 32'd0);
`endif

      // Reset in the middle of a frame
      bm.READY = 1'b1;
      tick(1);
      bm.READY = 1'b0;
      dm = 8'hFF;
      bm.START = 1'b1;
      tick(1);
      bm.START = 1'b0;
      tick(4);
      chk("mid_busy", 32'(bm.BUSY), 32'd1);
      chk("mid_ce",   32'(bm.CE_o), 32'd0);
      mr = 1'b1;
      tick(1);
      chk("mr_pl",    32'(bm.PL_o),  32'd1);
      chk("mr_ce",    32'(bm.CE_o),  32'd1);
      chk("mr_valid", 32'(bm.VALID), 32'd0);
      chk("mr_busy",  32'(bm.BUSY),  32'd0);
      chk("mr_q",     32'(bm.Q),     32'h00);
      tick(1);
      mr = 1'b0;
      force_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         force_val = (i % 2 == 0);
         tick(1);
         chk("post_mr_busy",  32'(bm.BUSY),  32'd0);
         chk("post_mr_valid", 32'(bm.VALID), 32'd0);
         chk("post_mr_q",     32'(bm.Q),     32'h00);
      end
      force_en = 1'b0;

      // LSB-first instance, pattern 0xB2 -> 0x4D
      dl = 8'hB2;
      bl.START = 1'b1;
      tick(1);
      bl.START = 1'b0;
      chk("lsb_pl", 32'(bl.PL_o), 32'd0);
      tick(9);
      chk("lsb_valid", 32'(bl.VALID), 32'd1);
      chk("lsb_q",     32'(bl.Q),     32'h4D);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/cyq_sipo_rx.md
Name: cyq_sipo_rx

Overview:
- Downstream companion of the 8-bit parallel-load shift register (74HC165-style). That register has an active-low async load PL, an active-low shift enable CE and a serial output Y.
- This block sequences the register: it pulses PL to capture the parallel inputs, then holds CE low for WIDTH cycles while sampling Y.
- It assembles the bits into a parallel word and presents it on a valid/ready handshake.
- Both blocks share the same clock CP.

Parameters:
- WIDTH, 8, bits per frame; must match the upstream register length; WIDTH >= 2.
- MSB_FIRST, 1, 1: first sampled bit lands in Q[WIDTH-1]; 0: first sampled bit lands in Q[0].

Ports:
- CP  input  1  clock, rising edge; also drives the upstream register.
- MR  input  1  reset, synchronous, active-high.
- START  input  1  frame request, level-sampled.
- PL_o  output  1  to upstream PL; active-low load pulse.
- CE_o  output  1  to upstream CE; active-low shift enable.
- Y_i  input  1  serial data from upstream Y.
- Q  output  WIDTH  assembled parallel word.
- VALID  output  1  Q holds an unread frame.
- READY  input  1  consumer accepts Q.
- BUSY  output  1  high in LOAD or SHIFT.

Behaviour:
- Single clock CP. Reset MR is synchronous and active-high. All outputs are registered.
- Reset values: PL_o=1, CE_o=1, Q=0, VALID=0, BUSY=0, bit counter=0, shift register=0, state=IDLE. ERR=0 when the optional feature is compiled in.
- IDLE: PL_o=1, CE_o=1, BUSY=0. Go to LOAD at an edge where START=1 and VALID=0.
- LOAD: exactly 1 cycle. PL_o=0, CE_o=1, BUSY=1. Next state is SHIFT, counter=0.
- SHIFT: exactly WIDTH cycles. PL_o=1, CE_o=0, BUSY=1.
  - At each edge, Y_i is sampled before the upstream shift takes effect.
  - With MSB_FIRST=1, the shift register shifts left and Y_i enters at bit 0. With MSB_FIRST=0, it shifts right and Y_i enters at bit WIDTH-1.
  - The counter increments at each edge.
  - At the edge taking the counter from WIDTH-1 to WIDTH: Q <= final assembled word (including this last sample), VALID <= 1, state <= DONE.
- DONE: PL_o=1, CE_o=1, BUSY=0, VALID=1. Q is stable until the handshake completes.
  - On an edge with READY=1: VALID <= 0.
  - If START=1 at that same edge, go directly to LOAD (back-to-back frames). Otherwise go to IDLE.
- Latency: START sampled at edge t0 gives PL_o=0 during (t0, t0+1]. Samples are taken at edges t0+2 .. t0+WIDTH+1. VALID=1 after edge t0+WIDTH+1.
- Upstream mapping (WIDTH=8, MSB_FIRST=1): after load, upstream Y = D[7]. Resulting Q[7:0] = {D[7],D[6],...,D[0]} of the upstream inputs.
- START while BUSY or while VALID=1 without READY: ignored, not queued.
- READY while VALID=0: ignored.
- MR mid-frame, in any state: the next edge forces the reset values. The partial word is discarded. PL_o and CE_o return high, so the upstream register stops shifting.
- MR has priority over START and READY.
- Q changes only at the DONE-entry edge and at reset.

Optional Feature:
- Macro: CYQ_SIPO_RX_INV_CHK_EN.
- Defined: adds input Yn_i (1 bit, from upstream Yn) and output ERR (1 bit, sticky).
  - At each SHIFT sampling edge, if Y_i == Yn_i then ERR <= 1.
  - ERR is cleared only by MR or by the LOAD-entry edge of the next frame.
  - ERR is valid alongside VALID.
- Undefined: no Yn_i or ERR ports; no comparison logic.

Test Plan:
- Reset: assert MR for 2 cycles, mid-SHIFT → next edge PL_o=1, CE_o=1, VALID=0, BUSY=0, Q=0x00; subsequent Y_i toggling has no effect.
- Single frame: model the upstream register with D[7..0]=1,0,1,1,0,0,1,0; pulse START at t0 → PL_o low for exactly 1 cycle, CE_o low for exactly 8 cycles, VALID rises at t0+9, Q=0xB2, BUSY=0 in DONE.
- Hold and handshake: keep READY=0 for 5 cycles after VALID and pulse START twice → Q stays 0xB2, no PL_o pulse; READY=1 for 1 cycle → VALID=0 next edge, state IDLE.
- Back-to-back: READY=1 and START=1 at the same edge with a second upstream pattern of 0x5A → PL_o low on the very next cycle, second VALID 10 edges after the first VALID, Q=0x5A.
- LSB-first: MSB_FIRST=0, same 0xB2 pattern → Q=0x4D.
- Inverted-output check (macro defined): Yn_i=~Y_i for a clean frame → ERR=0; force Yn_i=Y_i on sample 3 → ERR=1, held through DONE, cleared at the next LOAD.
